// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one registered ALU between two requesters. Grants one
//            command at a time (round-robin under contention), drives the
//            registered ALU operands, waits out the ALU latency, captures the
//            result and class flags, and returns them tagged with the
//            requester ID through a valid/ready response port.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_i, rst_i                  clock (rising edge), sync active-high reset
//   reqN_valid_i / reqN_ready_o   requester N command handshake (N = 0, 1)
//   reqN_a_i, reqN_b_i            requester N operands       [DATA_W]
//   reqN_fun_i                    requester N function code  [FUN_W]
//   alu_a_o, alu_b_o, alu_fun_o   registered operands/function to the ALU
//   alu_out_i                     ALU result                 [DATA_W]
//   arith/logic/cmp/shift_flag_i  ALU class flags
//   rsp_valid_o / rsp_ready_i     response handshake
//   rsp_id_o                      requester that issued the operation
//   rsp_data_o, rsp_flags_o       captured result, {Arith,Logic,CMP,Shift}
//   rsp_err_o                     operation rejected (divide by zero)
//   busy_o                        an operation is in progress
// ============================================================================
module alu_arbiter #(
  parameter int DATA_W  = 16,
  parameter int FUN_W   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // requester 0
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DATA_W-1:0] req0_a_i,
  input  logic [DATA_W-1:0] req0_b_i,
  input  logic [FUN_W-1:0]  req0_fun_i,
  // requester 1
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [DATA_W-1:0] req1_a_i,
  input  logic [DATA_W-1:0] req1_b_i,
  input  logic [FUN_W-1:0]  req1_fun_i,
  // ALU side
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [FUN_W-1:0]  alu_fun_o,
  input  logic [DATA_W-1:0] alu_out_i,
  input  logic              arith_flag_i,
  input  logic              logic_flag_i,
  input  logic              cmp_flag_i,
  input  logic              shift_flag_i,
  // response
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_id_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic [3:0]        rsp_flags_o,
  output logic              rsp_err_o,
  output logic              busy_o
);

  localparam int CNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT);
  localparam logic [FUN_W-1:0] FUN_NOP  = {FUN_W{1'b1}};
  localparam logic [FUN_W-1:0] FUN_DIV  = FUN_W'(3);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state_q,     state_d;
  logic              rr_ptr_q,    rr_ptr_d;
  logic              cooldown_q,  cooldown_d;
  logic [DATA_W-1:0] alu_a_q,     alu_a_d;
  logic [DATA_W-1:0] alu_b_q,     alu_b_d;
  logic [FUN_W-1:0]  alu_fun_q,   alu_fun_d;
  logic              id_q,        id_d;
  logic              err_q,       err_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q,    rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
  logic [3:0]        rsp_flags_q, rsp_flags_d;
  logic              rsp_err_q,   rsp_err_d;

  logic              w_grant0;
  logic              w_grant1;
  logic              w_open;
  logic [DATA_W-1:0] w_sel_a;
  logic [DATA_W-1:0] w_sel_b;
  logic [FUN_W-1:0]  w_sel_fun;
  logic              w_div0;

  // A lone valid always wins; under contention rr_ptr picks the winner.
  assign w_grant0 = req0_valid_i & (~req1_valid_i | ~rr_ptr_q);
  assign w_grant1 = req1_valid_i & (~req0_valid_i |  rr_ptr_q);

  // The cycle right after a response retires is a turnaround cycle with no
  // grant, which sets the peak cadence at one operation per ALU_LAT+4 cycles.
  assign w_open = (state_q == S_IDLE) & ~cooldown_q;

  assign req0_ready_o = w_open & w_grant0;
  assign req1_ready_o = w_open & w_grant1;

  assign w_sel_a   = w_grant1 ? req1_a_i   : req0_a_i;
  assign w_sel_b   = w_grant1 ? req1_b_i   : req0_b_i;
  assign w_sel_fun = w_grant1 ? req1_fun_i : req0_fun_i;

  // Divide by zero is never sent to the ALU; a NOP runs in its place so the
  // timing of the rejected operation matches a normal one.
  assign w_div0 = (w_sel_fun == FUN_DIV) && (w_sel_b == '0);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cooldown_d  = 1'b0;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_fun_d   = alu_fun_q;
    id_d        = id_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (req0_ready_o | req1_ready_o) begin
          alu_a_d   = w_sel_a;
          alu_b_d   = w_sel_b;
          alu_fun_d = w_div0 ? FUN_NOP : w_sel_fun;
          id_d      = req1_ready_o;
          err_d     = w_div0;
          cnt_d     = CNT_LOAD;
          rr_ptr_d  = ~req1_ready_o;
          state_d   = S_EXEC;
        end
      end

      S_EXEC: begin
        if (cnt_q == '0) begin
          rsp_id_d    = id_q;
          rsp_err_d   = err_q;
          rsp_data_d  = err_q ? '0 : alu_out_i;
          rsp_flags_d = err_q ? 4'b0000
                              : {arith_flag_i, logic_flag_i, cmp_flag_i, shift_flag_i};
          alu_fun_d   = FUN_NOP;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          cooldown_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= 1'b0;
      cooldown_q  <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= FUN_NOP;
      id_q        <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= 4'b0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cooldown_q  <= cooldown_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_fun_q   <= alu_fun_d;
      id_q        <= id_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_fun_o   = alu_fun_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_flags_o = rsp_flags_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule
`default_nettype wire
